// File: rtl/rx_frame_pkg.sv
// Shared frame layout, dispatcher state encoding and command classification
// for the receive-side frame dispatcher.
package rx_frame_pkg;

  localparam int CMD_W     = 8;
  localparam int PAYLOAD_W = 32;
  localparam int FRAME_W   = CMD_W + PAYLOAD_W;

  localparam logic [CMD_W-1:0] CMD_AUDIO_DEF = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_AUDIO_OUT = 2'd1,
    ST_CTRL_OUT  = 2'd2
  } disp_state_e;

  typedef enum logic [1:0] {
    CLS_AUDIO   = 2'd0,
    CLS_CTRL    = 2'd1,
    CLS_UNKNOWN = 2'd2
  } cmd_class_e;

  // The audio command has bit 7 set, so it must be matched before the
  // bit-7-clear control range test.
  function automatic cmd_class_e classify_cmd(input logic [CMD_W-1:0] cmd,
                                              input logic [CMD_W-1:0] audio_cmd);
    if (cmd == audio_cmd)
      return CLS_AUDIO;
    else if (!cmd[CMD_W-1])
      return CLS_CTRL;
    else
      return CLS_UNKNOWN;
  endfunction

endpackage

// File: rtl/rx_frame_dispatch_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; a push while full is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = LW'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rx_frame_dispatch.sv
// Buffers received frames, classifies the command byte and hands each frame
// in arrival order to the audio or control consumer; tracks drop/unknown stats.
module rx_frame_dispatch
  import rx_frame_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter logic [CMD_W-1:0] CMD_AUDIO = CMD_AUDIO_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FRAME_W-1:0]         frame_data,
  input  logic                       frame_valid,
  output logic [PAYLOAD_W-1:0]       audio_data,
  output logic                       audio_valid,
  input  logic                       audio_ready,
  output logic [CMD_W-1:0]           ctrl_cmd,
  output logic [PAYLOAD_W-1:0]       ctrl_payload,
  output logic                       ctrl_valid,
  input  logic                       ctrl_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic [7:0]                 overflow_count,
  output logic [7:0]                 bad_cmd_count,
  input  logic                       clear_status
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  disp_state_e        state, state_nxt;
  logic [FRAME_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop;
  logic               bad_evt;
  cmd_class_e         head_cls;

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_valid),
    .wdata (frame_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Stage 0: head-of-FIFO classification and pop decision
  assign head_cls = classify_cmd(head[FRAME_W-1 -: CMD_W], CMD_AUDIO);
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign drop     = frame_valid && fifo_full && !pop;
  assign bad_evt  = pop && (head_cls == CLS_UNKNOWN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_cls == CLS_AUDIO)     state_nxt = ST_AUDIO_OUT;
          else if (head_cls == CLS_CTRL) state_nxt = ST_CTRL_OUT;
        end
      end
      ST_AUDIO_OUT: if (audio_ready) state_nxt = ST_IDLE;
      ST_CTRL_OUT:  if (ctrl_ready)  state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Stage 1: output registers, loaded only on pop so they hold through backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_data   <= '0;
      ctrl_cmd     <= '0;
      ctrl_payload <= '0;
    end else if (pop) begin
      if (head_cls == CLS_AUDIO)
        audio_data <= head[PAYLOAD_W-1:0];
      if (head_cls == CLS_CTRL) begin
        ctrl_cmd     <= head[FRAME_W-1 -: CMD_W];
        ctrl_payload <= head[PAYLOAD_W-1:0];
      end
    end
  end

  assign audio_valid = (state == ST_AUDIO_OUT);
  assign ctrl_valid  = (state == ST_CTRL_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
      bad_cmd_count  <= '0;
    end else if (clear_status) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
      bad_cmd_count  <= '0;
    end else begin
      if (drop) begin
        overflow       <= 1'b1;
        overflow_count <= sat_inc8(overflow_count);
      end
      if (bad_evt)
        bad_cmd_count <= sat_inc8(bad_cmd_count);
    end
  end

endmodule
